// File: rtl/riscv_defs.sv
// Shared definitions for the data-memory port arbiter: FSM states, maintenance op bits, requester ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_defs;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT        = 3'd2,
    ST_MAINT_ISSUE = 3'd3,
    ST_MAINT_WAIT  = 3'd4
  } arb_state_e;

  // Bit positions inside the one-hot maintenance op {invalidate, writeback, flush}
  localparam int MAINT_FLUSH = 0;
  localparam int MAINT_WB    = 1;
  localparam int MAINT_INV   = 2;

  // Requester ids (also the round-robin pointer encoding)
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-input round-robin picker; pointer names the requester preferred on a tie.
// Latency: grant is combinational; pointer moves one cycle after a done pulse.
// Backpressure: none; caller decides when a grant is consumed and signals done.
module dmem_rr_arb2
  import riscv_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] grant
);

  logic ptr;

  // Pointer moves past the requester whose transaction just finished
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= REQ_ID0;
    end else if (done) begin
      ptr <= ~done_id;
    end
  end

  // A lone requester always wins; on a tie the pointer decides
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr == REQ_ID1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one MMU/D-cache port between two requesters and maintenance ops, one transaction in flight.
// Latency: accept -> issue -> (mem_valid) -> response, minimum 4 cycles; a hung access faults after TIMEOUT_CYCLES.
// Backpressure: requests/maint ops are held by the source until the combinational accept (IDLE only).
module dmem_port_arbiter
  import riscv_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_rd_i,
  input  logic        req0_wr_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_data_i,
  input  logic [3:0]  req0_mask_i,
  output logic        req0_accept_o,
  output logic        req0_valid_o,
  output logic [31:0] req0_value_o,
  output logic        req0_fault_o,
  input  logic        req1_rd_i,
  input  logic        req1_wr_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_data_i,
  input  logic [3:0]  req1_mask_i,
  output logic        req1_accept_o,
  output logic        req1_valid_o,
  output logic [31:0] req1_value_o,
  output logic        req1_fault_o,
  input  logic [2:0]  maint_op_i,
  output logic        maint_accept_o,
  output logic        maint_done_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_mask_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        mem_dflush_o,
  output logic        mem_dwriteback_o,
  output logic        mem_dinvalidate_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_value_i,
  input  logic        mem_load_fault_i,
  input  logic        mem_store_fault_i,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e       state, state_nxt;
  logic [1:0]       req_vld;
  logic [1:0]       grant;
  logic             maint_req;
  logic             take_acc;
  logic             take_maint;
  logic             win_id;
  logic             win_wr;
  logic [31:0]      win_addr;
  logic [31:0]      win_data;
  logic [3:0]       win_mask;
  logic             tmo_hit;
  logic             acc_done;
  logic             tmo_fire;
  logic             maint_fire;
  logic             owner;
  logic             is_wr;
  logic [CNT_W-1:0] cnt;

  assign req_vld = {req1_rd_i | req1_wr_i, req0_rd_i | req0_wr_i};

  dmem_rr_arb2 u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_vld),
    .done    (acc_done | tmo_fire),
    .done_id (owner),
    .grant   (grant)
  );

  // Next state and per-cycle control decode; maintenance outranks data requests
  always_comb begin
    state_nxt  = state;
    maint_req  = |maint_op_i;
    take_maint = 1'b0;
    take_acc   = 1'b0;
    win_id     = grant[1] ? REQ_ID1 : REQ_ID0;
    win_wr     = grant[1] ? req1_wr_i   : req0_wr_i;
    win_addr   = grant[1] ? req1_addr_i : req0_addr_i;
    win_data   = grant[1] ? req1_data_i : req0_data_i;
    win_mask   = grant[1] ? req1_mask_i : req0_mask_i;
    tmo_hit    = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LIMIT);
    acc_done   = 1'b0;
    tmo_fire   = 1'b0;
    maint_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (maint_req) begin
          take_maint = 1'b1;
          state_nxt  = ST_MAINT_ISSUE;
        end else if (|grant) begin
          take_acc  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_accept_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the timeout cycle takes precedence
        if (mem_valid_i) begin
          acc_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_MAINT_ISSUE: begin
        if (mem_accept_i) state_nxt = ST_MAINT_WAIT;
      end
      ST_MAINT_WAIT: begin
        if (mem_valid_i) begin
          maint_fire = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign maint_accept_o = take_maint;
  assign req0_accept_o  = take_acc & (win_id == REQ_ID0);
  assign req1_accept_o  = take_acc & (win_id == REQ_ID1);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Registered memory-side strobes, latched request and response pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner             <= REQ_ID0;
      is_wr             <= 1'b0;
      cnt               <= '0;
      mem_addr_o        <= '0;
      mem_data_o        <= '0;
      mem_mask_o        <= '0;
      mem_rd_o          <= 1'b0;
      mem_wr_o          <= 1'b0;
      mem_dflush_o      <= 1'b0;
      mem_dwriteback_o  <= 1'b0;
      mem_dinvalidate_o <= 1'b0;
      req0_valid_o      <= 1'b0;
      req0_value_o      <= '0;
      req0_fault_o      <= 1'b0;
      req1_valid_o      <= 1'b0;
      req1_value_o      <= '0;
      req1_fault_o      <= 1'b0;
      maint_done_o      <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      req0_valid_o <= 1'b0;
      req0_value_o <= '0;
      req0_fault_o <= 1'b0;
      req1_valid_o <= 1'b0;
      req1_value_o <= '0;
      req1_fault_o <= 1'b0;
      maint_done_o <= 1'b0;
      timeout_o    <= 1'b0;

      cnt <= (state == ST_WAIT) ? cnt + 1'b1 : '0;

      if (take_acc) begin
        owner      <= win_id;
        is_wr      <= win_wr;
        mem_addr_o <= win_addr & 32'hFFFF_FFFC;
        mem_data_o <= win_data;
        mem_mask_o <= win_wr ? win_mask : 4'hf;
        mem_rd_o   <= ~win_wr;
        mem_wr_o   <= win_wr;
      end
      if (state == ST_ISSUE && mem_accept_i) begin
        mem_rd_o <= 1'b0;
        mem_wr_o <= 1'b0;
      end

      if (take_maint) begin
        mem_dflush_o      <= maint_op_i[MAINT_FLUSH];
        mem_dwriteback_o  <= maint_op_i[MAINT_WB];
        mem_dinvalidate_o <= maint_op_i[MAINT_INV];
      end
      if (state == ST_MAINT_ISSUE && mem_accept_i) begin
        mem_dflush_o      <= 1'b0;
        mem_dwriteback_o  <= 1'b0;
        mem_dinvalidate_o <= 1'b0;
      end

      if (acc_done) begin
        if (owner == REQ_ID0) begin
          req0_valid_o <= 1'b1;
          req0_value_o <= is_wr ? 32'h0 : mem_value_i;
          req0_fault_o <= is_wr ? mem_store_fault_i : mem_load_fault_i;
        end else begin
          req1_valid_o <= 1'b1;
          req1_value_o <= is_wr ? 32'h0 : mem_value_i;
          req1_fault_o <= is_wr ? mem_store_fault_i : mem_load_fault_i;
        end
      end
      if (tmo_fire) begin
        timeout_o <= 1'b1;
        if (owner == REQ_ID0) begin
          req0_valid_o <= 1'b1;
          req0_fault_o <= 1'b1;
        end else begin
          req1_valid_o <= 1'b1;
          req1_fault_o <= 1'b1;
        end
      end

      if (maint_fire) maint_done_o <= 1'b1;
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single MMU/data-cache port between two requesters: req0 (LSU) and req1 (page-table walker or debug access).
- Also sequences cache-maintenance pulses (flush, writeback, invalidate) so they never overlap a data access.
- Allows one outstanding transaction; the response is routed back to its owner.
- A response timeout counter converts a hung access into a faulted response.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for mem_valid_i before the access is aborted; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be less than 2^CNT_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- reqN_rd_i / reqN_wr_i  in  1 each  read/write request from requester N (N=0,1); held until accepted
- reqN_addr_i  in  32  byte address
- reqN_data_i  in  32  write data
- reqN_mask_i  in  4  byte enables
- reqN_accept_o  out  1  request taken this cycle
- reqN_valid_o  out  1  one-cycle response pulse
- reqN_value_o  out  32  read data (0 for writes)
- reqN_fault_o  out  1  page fault or timeout; qualified by reqN_valid_o
- maint_op_i  in  3  one-hot {invalidate, writeback, flush}; held until accepted
- maint_accept_o  out  1  maintenance op taken
- maint_done_o  out  1  one-cycle completion pulse
- mem_addr_o  out  32  word-aligned address, bits [1:0] = 0
- mem_data_o  out  32  write data
- mem_mask_o  out  4  byte enables; 4'hf for reads
- mem_rd_o / mem_wr_o  out  1 each  access strobes
- mem_dflush_o / mem_dwriteback_o / mem_dinvalidate_o  out  1 each  maintenance strobes
- mem_accept_i  in  1  downstream took the strobe
- mem_valid_i  in  1  access or maintenance complete
- mem_value_i  in  32  read data
- mem_load_fault_i / mem_store_fault_i  in  1 each  faults; qualified by mem_valid_i
- timeout_o  out  1  one-cycle pulse when an access is aborted

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = req0; counter = 0. Reset mid-transaction abandons the transaction and emits no response.
- All mem_* outputs and all response outputs are registered. The accept outputs are combinational, asserted in IDLE only.
- States:
  - IDLE: picks at most one winner per cycle in priority order maintenance > round-robin among req0/req1. A requester that has both rd and wr set is treated as a write.
    - Access winner: latch addr/data/mask/owner/rd-or-wr → ISSUE.
    - Maintenance winner: latch op → MAINT_ISSUE.
  - ISSUE: drive mem_rd_o/mem_wr_o continuously. On mem_accept_i, drop the strobe next cycle → WAIT.
  - WAIT: counter increments each cycle. On mem_valid_i, the next cycle gives:
    - owner reqN_valid_o = 1;
    - reqN_value_o = mem_value_i for reads, 0 for writes;
    - reqN_fault_o = (rd & load_fault) | (wr & store_fault);
    - pointer moves past the owner; → IDLE.
  - WAIT timeout: when counter == TIMEOUT_CYCLES with no mem_valid_i, pulse timeout_o and owner reqN_valid_o with reqN_fault_o = 1 and value 0 → IDLE. If mem_valid_i arrives in the same cycle, mem_valid_i wins and there is no timeout.
  - MAINT_ISSUE: drive the strobe for the latched op until mem_accept_i → MAINT_WAIT.
  - MAINT_WAIT: on mem_valid_i, pulse maint_done_o → IDLE. No timeout applies.
- Throughput: minimum 4 cycles from accept to response: accept, issue with immediate accept, valid, response.
- Arbitration: both requesting with pointer = req0 → req0 wins and pointer becomes req1. A single requester always wins regardless of pointer.
- mem_valid_i in IDLE or ISSUE is ignored; it is a protocol error and produces no response.

Decomposition:
- Shared package (riscv_defs): state encodings, maintenance one-hot bit positions, requester id constants.
- One sub-module: dmem_rr_arb2, a two-input round-robin picker with pointer update on a grant-done pulse.

Test Plan:
- Read via req0 at 0x1003: mem_addr_o = 0x1000, mask 4'hf; mem_accept_i at +1, mem_valid_i at +3 with 0xDEADBEEF → req0_valid_o pulses with 0xDEADBEEF, req1 silent.
- req0 and req1 both requesting from reset, backlogged for 4 transactions → grant order 0,1,0,1, each response routed to the correct owner.
- Flush request at the same time as req0 and req1 → maint_accept_o first, mem_dflush_o held until accept, maint_done_o pulses, then req0 is served.
- Write by req1 with mem_store_fault_i = 1 on completion → req1_valid_o = 1, req1_fault_o = 1, value 0.
- TIMEOUT_CYCLES = 4, no mem_valid_i → timeout_o and req0_fault_o pulse 4 cycles after entering WAIT, then a new request is accepted.
- rst_i asserted during WAIT → all outputs 0 immediately; a late mem_valid_i after reset release produces no response.
